// File: rtl/fx3_pkg.sv
// Shared definitions for the FX3 GPIF II master emulator:
// state encoding, counter widths and default packet length.
package fx3_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        RECEIVE = 2'd2,
        GAP     = 2'd3
    } state_t;

    localparam int PACKET_WORDS_DEF = 8192;
    localparam int CNT_W            = 16;
    localparam int WCNT_W           = 15;

    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/fx3_gpif_master_if.sv
// Packet handshake between the GPIF master emulator and the FPGA packet responder.
interface fx3_gpif_master_if;
    import fx3_pkg::*;

    logic       fx3isReading;
    cnt_t       dataIn;
    logic       readData;

    modport master (input fx3isReading, input dataIn, output readData);
    modport slave  (output fx3isReading, output dataIn, input readData);

endinterface

// File: rtl/sat_counter16.sv
// 16-bit status counter: increment, synchronous clear, async reset,
// and a select between saturating at all-ones or wrapping to zero.
module sat_counter16
    import fx3_pkg::*;
(
    input  logic inclk,
    input  logic nReset,
    input  logic i_clr,
    input  logic i_inc,
    input  logic i_sat,
    output cnt_t o_q
);

    cnt_t r_q;

    always_ff @(posedge inclk or negedge nReset) begin
        if (!nReset)
            r_q <= '0;
        else if (i_clr)
            r_q <= '0;
        else if (i_inc && !(i_sat && (&r_q)))
            r_q <= r_q + 1'b1;
    end

    assign o_q = r_q;

endmodule

// File: rtl/fx3_gpif_master.sv
// FX3 GPIF II side emulator: requests packets, captures words while the
// responder flags a packet, checks length and an incrementing data pattern.
module fx3_gpif_master
    import fx3_pkg::*;
#(
    parameter int PACKET_WORDS = PACKET_WORDS_DEF,
    parameter int REQ_TIMEOUT  = 1024,
    parameter int GAP_CYCLES   = 4
) (
    input  logic                     inclk,
    input  logic                     nReset,
    input  logic                     enable,
    input  logic                     checkEnable,
    fx3_gpif_master_if.master        bus,
    output logic                     packetDone,
    output cnt_t                     packetCount,
    output cnt_t                     lengthErrors,
    output cnt_t                     dataErrors,
    output logic                     timeoutFlag,
    output logic                     busy
);

    state_t              r_state;
    state_t              w_next;
    logic                r_fxr;
    logic                r_fxr_d;
    cnt_t                r_din;
    cnt_t                r_exp;
    logic                r_seeded;
    logic [15:0]         r_tcnt;
    logic [WCNT_W-1:0]   r_wcnt;
    logic                r_done;
    logic                r_tmo;

    logic w_tmo_hit, w_gap_hit;
    logic w_rd, w_cap, w_pkt_end, w_tmo_evt, w_spur;
    logic w_derr, w_lerr;

    // One shared timer: request timeout in REQUEST, idle spacing in GAP.
    assign w_tmo_hit = (r_tcnt == 16'(REQ_TIMEOUT - 1));
    assign w_gap_hit = (r_tcnt == 16'(GAP_CYCLES - 1));

    always_ff @(posedge inclk or negedge nReset) begin
        if (!nReset) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (enable) w_next = REQUEST;
            REQUEST: if (r_fxr) w_next = RECEIVE;
                     else if (w_tmo_hit) w_next = GAP;
            RECEIVE: if (!r_fxr) w_next = GAP;
            GAP:     if (w_gap_hit) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // The word registered with the first fxr is captured while still in REQUEST.
    always_comb begin
        w_rd      = 1'b0;
        w_cap     = 1'b0;
        w_pkt_end = 1'b0;
        w_tmo_evt = 1'b0;
        w_spur    = 1'b0;
        unique case (r_state)
            REQUEST: begin
                w_rd      = 1'b1;
                w_cap     = r_fxr;
                w_tmo_evt = !r_fxr && w_tmo_hit;
            end
            RECEIVE: begin
                w_cap     = r_fxr;
                w_pkt_end = !r_fxr;
            end
            GAP:     w_spur = r_fxr && !r_fxr_d;
            default: ;
        endcase
    end

    assign bus.readData = w_rd;
    assign busy         = (r_state != IDLE);
    assign packetDone   = r_done;
    assign timeoutFlag  = r_tmo;

    always_ff @(posedge inclk or negedge nReset) begin
        if (!nReset) begin
            r_fxr    <= 1'b0;
            r_fxr_d  <= 1'b0;
            r_din    <= '0;
            r_exp    <= '0;
            r_seeded <= 1'b0;
            r_tcnt   <= '0;
            r_wcnt   <= '0;
            r_done   <= 1'b0;
            r_tmo    <= 1'b0;
        end else begin
            r_fxr   <= bus.fx3isReading;
            r_fxr_d <= r_fxr;
            r_din   <= bus.dataIn;
            r_done  <= w_pkt_end;
            r_tcnt  <= (w_next != r_state) ? '0 : r_tcnt + 16'd1;
            if (w_tmo_evt)
                r_tmo <= 1'b1;
            if (r_state == IDLE)
                r_wcnt <= '0;
            else if (w_cap && !(&r_wcnt))
                r_wcnt <= r_wcnt + 15'd1;
            // Follow the received data so one bad word cannot poison the rest.
            if (w_cap) begin
                r_exp    <= r_din + 16'd1;
                r_seeded <= 1'b1;
            end
        end
    end

    assign w_derr = w_cap && checkEnable && r_seeded && (r_din != r_exp);
    assign w_lerr = (w_pkt_end && (r_wcnt != WCNT_W'(PACKET_WORDS))) || w_spur;

    sat_counter16 u_pkt_cnt (
        .inclk(inclk), .nReset(nReset), .i_clr(1'b0),
        .i_inc(w_pkt_end), .i_sat(1'b0), .o_q(packetCount)
    );

    sat_counter16 u_len_cnt (
        .inclk(inclk), .nReset(nReset), .i_clr(1'b0),
        .i_inc(w_lerr), .i_sat(1'b1), .o_q(lengthErrors)
    );

    sat_counter16 u_dat_cnt (
        .inclk(inclk), .nReset(nReset), .i_clr(1'b0),
        .i_inc(w_derr), .i_sat(1'b1), .o_q(dataErrors)
    );

endmodule
